// File: rtl/t_column_buffer_if.sv
// Loader, PE-0 feed and last-PE write-back bundle of the T column buffer.
// Master is the controller/PE side, slave is the buffer itself.
interface t_column_buffer_if #(
    parameter int T_MAX_LEN = 1024,
    parameter int VEF_BIT   = 16
);
    localparam int LW = $clog2(T_MAX_LEN) + 1;

    logic               i_start;
    logic [VEF_BIT-1:0] i_minusAlpha;
    logic [1:0]         i_t_in;
    logic               i_t_in_valid;
    logic               i_t_in_last;
    logic               o_t_in_ready;
    logic               i_pass_start;
    logic               i_lock;
    logic [1:0]         o_t;
    logic [VEF_BIT-1:0] o_v;
    logic [VEF_BIT-1:0] o_v_a;
    logic [VEF_BIT-1:0] o_f;
    logic               o_t_newline;
    logic               o_enable_0;
    logic [1:0]         i_t;
    logic [VEF_BIT-1:0] i_v;
    logic [VEF_BIT-1:0] i_f;
    logic               i_t_valid;
    logic               o_pass_done;
    logic [LW-1:0]      o_len;
    logic               o_overflow;

    modport master (
        output i_start, i_minusAlpha, i_t_in, i_t_in_valid, i_t_in_last,
        output i_pass_start, i_lock, i_t, i_v, i_f, i_t_valid,
        input  o_t_in_ready, o_t, o_v, o_v_a, o_f, o_t_newline, o_enable_0,
        input  o_pass_done, o_len, o_overflow
    );

    modport slave (
        input  i_start, i_minusAlpha, i_t_in, i_t_in_valid, i_t_in_last,
        input  i_pass_start, i_lock, i_t, i_v, i_f, i_t_valid,
        output o_t_in_ready, o_t, o_v, o_v_a, o_f, o_t_newline, o_enable_0,
        output o_pass_done, o_len, o_overflow
    );
endinterface

// File: rtl/t_column_buffer.sv
// Holds T plus the last-PE boundary column and replays it into PE 0 once per pass;
// the last PE's write-back overwrites each entry in place for the next pass.
module t_column_buffer #(
    parameter int PE_ARRAY_SIZE = 64,
    parameter int T_MAX_LEN     = 1024,
    parameter int VEF_BIT       = 16
) (
    input logic             clk,
    input logic             rst_n,
    t_column_buffer_if.slave bus
);
    localparam int AW = $clog2(T_MAX_LEN);
    localparam int LW = AW + 1;
    localparam int DW = 2 + 3 * VEF_BIT;
    localparam logic [LW-1:0] DEPTH = LW'(T_MAX_LEN);

    // Reads lead write-backs by the array latency, so this distance must be positive.
    if (PE_ARRAY_SIZE < 1) begin : g_bad_pe_array_size
        $error("PE_ARRAY_SIZE must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, RUN, DRAIN} state_t;

    state_t        state_reg;
    logic [LW-1:0] len_reg;
    logic [LW-1:0] rd_ptr_reg;
    logic [LW-1:0] wr_ptr_reg;
    logic          overflow_reg;
    logic          enable_reg;
    logic          newline_reg;
    logic          pass_done_reg;

    // Entry layout {t, v, v_a, f}; v_a is folded in at write time so the feed stays registered.
    logic [DW-1:0] mem [T_MAX_LEN];
    logic [DW-1:0] rd_data_reg;

    logic               load_acc;
    logic               load_wr;
    logic               wb_acc;
    logic               rd_en;
    logic [VEF_BIT:0]   va_sum;
    logic [VEF_BIT-1:0] va_clamp;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;

    assign load_acc = (state_reg == LOAD) && bus.i_t_in_valid && !bus.i_lock;
    assign load_wr  = load_acc && (len_reg < DEPTH);
    assign wb_acc   = ((state_reg == RUN) || (state_reg == DRAIN)) && bus.i_t_valid
                      && !bus.i_lock && (wr_ptr_reg != len_reg);
    assign rd_en    = (state_reg == RUN) && !bus.i_lock;

    // Sign-extended sum cannot wrap, so its top bit is the true sign for the clamp.
    assign va_sum   = {bus.i_v[VEF_BIT-1], bus.i_v}
                    + {bus.i_minusAlpha[VEF_BIT-1], bus.i_minusAlpha};
    assign va_clamp = va_sum[VEF_BIT] ? '0 : va_sum[VEF_BIT-1:0];

    always_comb begin
        mem_we    = load_wr || wb_acc;
        mem_addr  = len_reg[AW-1:0];
        mem_wdata = {bus.i_t_in, {(3 * VEF_BIT){1'b0}}};
        if (wb_acc) begin
            mem_addr  = wr_ptr_reg[AW-1:0];
            mem_wdata = {bus.i_t, bus.i_v, va_clamp, bus.i_f};
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            overflow_reg  <= 1'b0;
            enable_reg    <= 1'b0;
            newline_reg   <= 1'b0;
            pass_done_reg <= 1'b0;
        end else if (!bus.i_lock) begin
            enable_reg    <= (state_reg == RUN);
            newline_reg   <= (state_reg == RUN) && (rd_ptr_reg == '0);
            pass_done_reg <= 1'b0;
            if (wb_acc) begin
                wr_ptr_reg <= wr_ptr_reg + LW'(1);
            end
            case (state_reg)
                IDLE: begin
                    if (bus.i_start) begin
                        len_reg      <= '0;
                        overflow_reg <= 1'b0;
                        state_reg    <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.i_t_in_valid) begin
                        if (len_reg < DEPTH) begin
                            len_reg <= len_reg + LW'(1);
                        end else begin
                            overflow_reg <= 1'b1;
                        end
                        if (bus.i_t_in_last) begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.i_pass_start) begin
                        rd_ptr_reg <= '0;
                        wr_ptr_reg <= '0;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    rd_ptr_reg <= rd_ptr_reg + LW'(1);
                    if (rd_ptr_reg == len_reg - LW'(1)) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Pulse lands in the cycle right after the final write-back.
                    if ((wb_acc && (wr_ptr_reg == len_reg - LW'(1))) || (wr_ptr_reg == len_reg)) begin
                        pass_done_reg <= 1'b1;
                        state_reg     <= WAIT;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.o_t_in_ready = (state_reg == LOAD) && !bus.i_lock;
    assign bus.o_enable_0   = enable_reg;
    assign bus.o_t_newline  = newline_reg;
    assign bus.o_t          = enable_reg ? rd_data_reg[DW-1 -: 2] : '0;
    assign bus.o_v          = enable_reg ? rd_data_reg[3*VEF_BIT-1 -: VEF_BIT] : '0;
    assign bus.o_v_a        = enable_reg ? rd_data_reg[2*VEF_BIT-1 -: VEF_BIT] : '0;
    assign bus.o_f          = enable_reg ? rd_data_reg[VEF_BIT-1:0] : '0;
    assign bus.o_pass_done  = pass_done_reg;
    assign bus.o_len        = len_reg;
    assign bus.o_overflow   = overflow_reg;
endmodule

// File: tb/tb_t_column_buffer.sv
// Scoreboard bench for t_column_buffer: stimulus queues expected PE-0 symbols,
// a negedge monitor pops and compares each symbol PE 0 actually consumes.
module tb_t_column_buffer;
    localparam int TL = 8;
    localparam int VB = 16;

    typedef struct packed {
        logic [1:0]    t;
        logic [VB-1:0] v;
        logic [VB-1:0] va;
        logic [VB-1:0] f;
        logic          nl;
    } sym_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   pd_count = 0;
    int   sym_idx = 0;
    sym_t exp_q[$];

    t_column_buffer_if #(.T_MAX_LEN(TL), .VEF_BIT(VB)) bus ();

    t_column_buffer #(.PE_ARRAY_SIZE(4), .T_MAX_LEN(TL), .VEF_BIT(VB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic sym_t mk(int t, int v, int va, int f, bit nl);
        sym_t s;
        s.t  = 2'(t);
        s.v  = VB'(v);
        s.va = VB'(va);
        s.f  = VB'(f);
        s.nl = nl;
        return s;
    endfunction

    // PE 0 consumes a symbol on each unlocked cycle with enable high.
    always @(negedge clk) begin
        if (rst_n && !bus.i_lock) begin
            if (bus.o_pass_done) pd_count++;
            if (bus.o_enable_0) begin
                sym_t got;
                sym_t e;
                got = {bus.o_t, bus.o_v, bus.o_v_a, bus.o_f, bus.o_t_newline};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sym_unexpected got=%h required=none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL sym%0d got=%h required=%h", sym_idx, got, e);
                    end else begin
                        $display("sym%0d t=%0d v=%0d va=%0d f=%0d nl=%0b", sym_idx,
                                 got.t, got.v, got.va, got.f, got.nl);
                    end
                end
                sym_idx++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end else begin
            $display("%s = %0h", name, got);
        end
    endtask

    task automatic load(int n, int base, int lock_at);
        bus.i_start = 1'b1;
        tick;
        bus.i_start = 1'b0;
        chk("ready_in_load", 32'(bus.o_t_in_ready), 1);
        for (int i = 0; i < n; i++) begin
            bus.i_t_in       = 2'((base + i) % 4);
            bus.i_t_in_last  = (i == n - 1);
            bus.i_t_in_valid = 1'b1;
            if (i == lock_at) begin
                bus.i_lock = 1'b1;
                tick;
                chk("ready_locked", 32'(bus.o_t_in_ready), 0);
                tick;
                tick;
                bus.i_lock = 1'b0;
            end
            tick;
        end
        bus.i_t_in_valid = 1'b0;
        bus.i_t_in_last  = 1'b0;
    endtask

    task automatic start_pass;
        bus.i_pass_start = 1'b1;
        tick;
        bus.i_pass_start = 1'b0;
    endtask

    task automatic wait_empty(int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick;
            n++;
        end
        chk("pass_symbols_left", 32'(exp_q.size()), 0);
        tick;
    endtask

    task automatic wb(int t, int v, int f);
        bus.i_t       = 2'(t);
        bus.i_v       = VB'(v);
        bus.i_f       = VB'(f);
        bus.i_t_valid = 1'b1;
        tick;
        bus.i_t_valid = 1'b0;
    endtask

    task automatic wait_pd(int target);
        int n = 0;
        while (pd_count < target && n < 40) begin
            tick;
            n++;
        end
        repeat (3) tick;
        chk("pass_done_count", 32'(pd_count), 32'(target));
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        bus.i_start      = 1'b0;
        bus.i_minusAlpha = VB'(-2);
        bus.i_t_in       = '0;
        bus.i_t_in_valid = 1'b0;
        bus.i_t_in_last  = 1'b0;
        bus.i_pass_start = 1'b0;
        bus.i_lock       = 1'b0;
        bus.i_t          = '0;
        bus.i_v          = '0;
        bus.i_f          = '0;
        bus.i_t_valid    = 1'b0;

        repeat (2) tick;
        chk("rst_enable", 32'(bus.o_enable_0), 0);
        chk("rst_newline", 32'(bus.o_t_newline), 0);
        chk("rst_len", 32'(bus.o_len), 0);
        chk("rst_overflow", 32'(bus.o_overflow), 0);
        chk("rst_ready", 32'(bus.o_t_in_ready), 0);
        chk("rst_pass_done", 32'(bus.o_pass_done), 0);
        rst_n = 1'b1;
        tick;

        // Load 0,1,2,3 and first pass with zero boundary
        load(4, 0, -1);
        chk("len_4", 32'(bus.o_len), 4);
        chk("overflow_4", 32'(bus.o_overflow), 0);
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(i, 0, 0, 0, i == 0));
        start_pass;
        wait_empty(40);
        wb(0, 5, 1); wb(1, 7, 2); wb(2, 3, 0); wb(3, 9, 4);
        wait_pd(1);

        // Pass 1: replay with lock mid-RUN and a stray pass_start
        exp_q.push_back(mk(0, 5, 3, 1, 1));
        exp_q.push_back(mk(1, 7, 5, 2, 0));
        exp_q.push_back(mk(2, 3, 1, 0, 0));
        exp_q.push_back(mk(3, 9, 7, 4, 0));
        start_pass;
        tick;
        bus.i_lock = 1'b1;
        repeat (3) tick;
        bus.i_lock = 1'b0;
        start_pass;
        wait_empty(40);
        // Write-back with a 3-cycle lock holding valid high
        wb(0, 6, 1); wb(1, 8, 0);
        bus.i_t = 2'd2; bus.i_v = VB'(2); bus.i_f = VB'(3); bus.i_t_valid = 1'b1;
        bus.i_lock = 1'b1;
        repeat (3) tick;
        bus.i_lock = 1'b0;
        tick;
        bus.i_t_valid = 1'b0;
        wb(3, 1, 1);
        wait_pd(2);
        wb(3, 15, 15);

        // Pass 2: v_a clamp at zero, locked write not duplicated
        exp_q.push_back(mk(0, 6, 4, 1, 1));
        exp_q.push_back(mk(1, 8, 6, 0, 0));
        exp_q.push_back(mk(2, 2, 0, 3, 0));
        exp_q.push_back(mk(3, 1, 0, 1, 0));
        start_pass;
        wait_empty(40);
        wb(0, 1, 1); wb(1, 1, 1); wb(2, 1, 1); wb(3, 1, 1); wb(0, 12, 12);
        wait_pd(3);

        // Pass 3 interrupted by reset
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(i, 1, 0, 1, i == 0));
        start_pass;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        chk("midrst_enable", 32'(bus.o_enable_0), 0);
        chk("midrst_t", 32'(bus.o_t), 0);
        chk("midrst_v", 32'(bus.o_v), 0);
        chk("midrst_len", 32'(bus.o_len), 0);
        exp_q.delete();
        tick;
        rst_n = 1'b1;
        tick;

        // len=1 reload, two passes
        load(1, 2, -1);
        chk("len_1", 32'(bus.o_len), 1);
        exp_q.push_back(mk(2, 0, 0, 0, 1));
        start_pass;
        wait_empty(20);
        wb(2, 4, 0);
        wait_pd(4);
        exp_q.push_back(mk(2, 4, 2, 0, 1));
        start_pass;
        wait_empty(20);
        wb(1, 0, 0);
        wait_pd(5);

        // Overflow: 10 symbols into 8 entries, lock during load
        do_reset;
        load(10, 0, 3);
        chk("len_ovf", 32'(bus.o_len), 8);
        chk("overflow_set", 32'(bus.o_overflow), 1);
        for (int i = 0; i < 8; i++) exp_q.push_back(mk(i % 4, 0, 0, 0, i == 0));
        start_pass;
        wait_empty(40);
        chk("overflow_sticky", 32'(bus.o_overflow), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
